// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-channel initiator.
// Response codes, burst types, read-master state encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_FIN
    } rm_state_e;

    // A command is unusable when its beat is wider than the bus
    // or when it asks for the reserved burst encoding.
    function automatic logic cmd_illegal(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [2:0] max_size
    );
        return (size > max_size) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/axi_skid_fifo.sv
// Two-entry beat buffer between the R channel and the output stream.
// Head entry is always visible on rdata; pop is ignored when empty.
module axi_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wp;
    logic             rp;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    // Pointer and occupancy tracking; push+pop together keeps count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) wp <= ~wp;
            if (do_pop)  rp <= ~rp;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    // Storage for the two beats.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_push) begin
            mem[wp] <= wdata;
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read-channel initiator: one burst at a time, AR issue, R collect.
// Optional macro AXI_READ_MASTER_RLAST_CHECK_EN flags rlast mismatches.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_SIZE      = $clog2(STROBE_WIDTH)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    rm_state_e       state;
    rm_state_e       state_nxt;
    logic [8:0]      remaining;
    logic            bad;
    logic            accept;
    logic            r_hs;
    logic            last_beat;
    logic            beat_err;
    logic            cmd_bad;
    logic            fifo_full;
    logic            fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;

    assign last_beat = (remaining == 9'd1);
    assign cmd_bad   = cmd_illegal(cmd_size, cmd_burst, 3'(MAX_SIZE));

`ifdef AXI_READ_MASTER_RLAST_CHECK_EN
    assign beat_err = (rresp != RESP_OKAY) || (rlast != last_beat);
`else
    logic unused_rlast;
    assign unused_rlast = rlast;
    assign beat_err     = (rresp != RESP_OKAY);
`endif

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; rready only from registered full.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        r_hs      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bad) begin
                    state_nxt = S_FIN;
                end else begin
                    arvalid = 1'b1;
                    if (arready) state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rready = !fifo_full;
                r_hs   = rvalid && !fifo_full;
                if (r_hs && last_beat) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command capture, beat countdown and sticky error.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arburst   <= '0;
            remaining <= '0;
            bad       <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            araddr    <= cmd_addr;
            arlen     <= cmd_len;
            arsize    <= cmd_size;
            arburst   <= cmd_burst;
            remaining <= {1'b0, cmd_len} + 9'd1;
            bad       <= cmd_bad;
            err       <= cmd_bad;
        end else if (r_hs) begin
            remaining <= remaining - 9'd1;
            if (beat_err) err <= 1'b1;
        end
    end

    axi_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (r_hs),
        .wdata  ({rdata, last_beat}),
        .full   (fifo_full),
        .pop    (out_ready),
        .rdata  (fifo_head),
        .empty  (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_WIDTH:1];
    assign out_last  = fifo_head[0];

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master with an output scoreboard.
// Expected beats are queued when a burst is commanded.
module tb_axi_read_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    int beats_taken;
    logic [31:0] beat_mem [256];
    logic [32:0] exp_q [$];

    always #5 aclk = ~aclk;

    axi_read_master dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Output stream monitor: every delivered beat must match the queue head.
    always @(negedge aclk) begin
        if (!areset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_beat", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e[32:1]));
                chk("out_last", 64'(out_last), 64'(e[0]));
            end
        end
    end

    task automatic push_exp(input int len);
        for (int i = 0; i <= len; i++) begin
            beat_mem[i] = $urandom;
            exp_q.push_back({beat_mem[i], (i == len)});
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b,
                            input logic exp_err);
        @(negedge aclk);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        chk("err_on_accept", 64'(err), 64'(exp_err));
        chk("busy_on_accept", 64'(busy), 64'd1);
    endtask

    task automatic do_ar(input int delay, input logic [7:0] a,
                         input logic [7:0] l, input logic [2:0] s);
        int   g;
        logic hs;
        arready = 1'b0;
        for (int k = 0; k < delay; k++) begin
            @(negedge aclk);
            chk("arvalid_wait", 64'(arvalid), 64'd1);
            chk("araddr_wait", 64'(araddr), 64'(a));
            chk("arlen_wait", 64'(arlen), 64'(l));
        end
        g  = 0;
        hs = 1'b0;
        while (!hs && g < 20) begin
            @(negedge aclk);
            arready = 1'b1;
            hs = arvalid;
            if (hs) begin
                chk("araddr", 64'(araddr), 64'(a));
                chk("arlen", 64'(arlen), 64'(l));
                chk("arsize", 64'(arsize), 64'(s));
                chk("arburst", 64'(arburst), 64'(2'b01));
            end
            @(posedge aclk);
            g++;
        end
        #1;
        arready = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic r_beats(input int len, input int err_idx,
                           input int last_idx);
        int   g;
        logic hs;
        g = 0;
        beats_taken = 0;
        while (beats_taken <= len && g < 3000) begin
            @(negedge aclk);
            rvalid = 1'b1;
            rdata  = beat_mem[beats_taken];
            rresp  = (beats_taken == err_idx) ? 2'b10 : 2'b00;
            rlast  = (beats_taken == last_idx);
            hs     = rready;
            @(posedge aclk);
            if (hs) beats_taken++;
            g++;
        end
        chk("r_beats_taken", 64'(beats_taken), 64'(len + 1));
        @(negedge aclk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge aclk);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fin_checks(input logic exp_err);
        chk("done_pulse", 64'(done), 64'd1);
        chk("err_at_done", 64'(err), 64'(exp_err));
        @(negedge aclk);
        chk("done_single", 64'(done), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        logic exp_rl_err;
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        cmd_burst = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Basic 4-beat INCR burst, back-to-back OKAY beats
        push_exp(3);
        send_cmd(8'h10, 8'd3, 3'd2, 2'b01, 1'b0);
        do_ar(0, 8'h10, 8'd3, 3'd2);
        r_beats(3, -1, 3);
        fin_checks(1'b0);
        drain();

        // Output stalled during an 8-beat burst
        out_ready = 1'b0;
        push_exp(7);
        send_cmd(8'h40, 8'd7, 3'd2, 2'b01, 1'b0);
        do_ar(0, 8'h40, 8'd7, 3'd2);
        fork
            r_beats(7, -1, 7);
            begin
                repeat (10) @(negedge aclk);
                chk("stall_rready", 64'(rready), 64'd0);
                chk("stall_taken", 64'(beats_taken), 64'd2);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                @(posedge aclk);
                #2;
                out_ready = 1'b1;
            end
        join
        fin_checks(1'b0);
        drain();

        // SLVERR on the second beat: all beats forwarded, err sticky
        push_exp(3);
        send_cmd(8'h20, 8'd3, 3'd2, 2'b01, 1'b0);
        do_ar(0, 8'h20, 8'd3, 3'd2);
        r_beats(3, 1, 3);
        fin_checks(1'b1);
        drain();
        repeat (3) @(negedge aclk);
        chk("err_sticky", 64'(err), 64'd1);

        // Oversized beat: no AR, err set, done two cycles after accept
        send_cmd(8'h30, 8'd1, 3'd3, 2'b01, 1'b1);
        @(negedge aclk);
        chk("bad_arvalid_1", 64'(arvalid), 64'd0);
        chk("bad_done_early", 64'(done), 64'd0);
        @(negedge aclk);
        chk("bad_arvalid_2", 64'(arvalid), 64'd0);
        chk("bad_done", 64'(done), 64'd1);
        @(negedge aclk);
        chk("bad_done_off", 64'(done), 64'd0);
        chk("bad_idle", 64'(busy), 64'd0);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_no_out", 64'(out_valid), 64'd0);

        // arready held off for 5 cycles; accept clears err
        push_exp(1);
        send_cmd(8'h5C, 8'd1, 3'd2, 2'b01, 1'b0);
        do_ar(5, 8'h5C, 8'd1, 3'd2);
        @(negedge aclk);
        chk("data_rready", 64'(rready), 64'd1);
        r_beats(1, -1, 1);
        fin_checks(1'b0);
        drain();

        // Early rlast on beat 2 of 4
`ifdef AXI_READ_MASTER_RLAST_CHECK_EN
        exp_rl_err = 1'b1;
`else
        exp_rl_err = 1'b0;
`endif
        push_exp(3);
        send_cmd(8'h80, 8'd3, 3'd2, 2'b01, 1'b0);
        do_ar(0, 8'h80, 8'd3, 3'd2);
        r_beats(3, -1, 1);
        fin_checks(exp_rl_err);
        drain();

        // Longest burst: 256 beats
        push_exp(255);
        send_cmd(8'h00, 8'd255, 3'd2, 2'b01, 1'b0);
        do_ar(0, 8'h00, 8'd255, 3'd2);
        r_beats(255, -1, 255);
        fin_checks(1'b0);
        drain();
        @(negedge aclk);
        chk("end_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
